// File: rtl/channel_accum.sv
// rtl/channel_accum.sv - per-channel phase accumulator with bias, shift, ReLU and saturation
module channel_accum #(
  parameter int DATA_LEN = 16,
  parameter int ACC_LEN  = DATA_LEN + 8,
  parameter int SHIFT    = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [2:0]                 n_phase,
  input  logic signed [DATA_LEN-1:0] bias,
  input  logic                       in_valid,
  input  logic signed [DATA_LEN-1:0] d,
  output logic                       busy,
  output logic                       valid,
  output logic signed [DATA_LEN-1:0] q,
  output logic                       err
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_BIAS, S_OUT} state_t;

  localparam logic signed [ACC_LEN-1:0] MAX_POS =
    {{(ACC_LEN-DATA_LEN+1){1'b0}}, {(DATA_LEN-1){1'b1}}};

  state_t                      r_state;
  state_t                      w_next;
  logic                        r_in_valid_d;
  logic signed [ACC_LEN-1:0]   r_acc;
  logic [2:0]                  r_cnt;
  logic [2:0]                  r_n_lat;
  logic signed [DATA_LEN-1:0]  r_b_lat;
  logic                        w_sample;
  logic signed [ACC_LEN-1:0]   w_d_ext;
  logic signed [ACC_LEN-1:0]   w_b_ext;
  logic signed [ACC_LEN-1:0]   w_shifted;
  logic signed [DATA_LEN-1:0]  w_sat;

  assign w_sample  = in_valid & ~r_in_valid_d;
  assign w_d_ext   = {{(ACC_LEN-DATA_LEN){d[DATA_LEN-1]}}, d};
  assign w_b_ext   = {{(ACC_LEN-DATA_LEN){r_b_lat[DATA_LEN-1]}}, r_b_lat};
  assign w_shifted = r_acc >>> SHIFT;
  assign busy      = (r_state != S_IDLE);

  // ReLU clamps negatives to zero, then positive overflow saturates
  always_comb begin
    w_sat = w_shifted[DATA_LEN-1:0];
    if (w_shifted < 0)
      w_sat = '0;
    else if (w_shifted > MAX_POS)
      w_sat = MAX_POS[DATA_LEN-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (start) begin
      w_next = S_ACCUM;
    end else begin
      case (r_state)
        S_ACCUM: if (w_sample && (r_cnt == r_n_lat)) w_next = S_BIAS;
        S_BIAS:  w_next = S_OUT;
        S_OUT:   w_next = S_IDLE;
        default: w_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_valid_d <= 1'b0;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_n_lat      <= '0;
      r_b_lat      <= '0;
      valid        <= 1'b0;
      q            <= '0;
      err          <= 1'b0;
    end else begin
      r_in_valid_d <= in_valid;
      valid        <= 1'b0;
      if (start) begin
        // a sample rising together with start is dropped on purpose
        r_acc   <= '0;
        r_cnt   <= '0;
        r_n_lat <= n_phase;
        r_b_lat <= bias;
        err     <= 1'b0;
      end else begin
        case (r_state)
          S_ACCUM: begin
            if (w_sample) begin
              r_acc <= r_acc + w_d_ext;
              r_cnt <= r_cnt + 3'd1;
            end
          end
          S_BIAS: r_acc <= r_acc + w_b_ext;
          S_OUT: begin
            q     <= w_sat;
            valid <= 1'b1;
          end
          default: ;
        endcase
        if (w_sample && (r_state != S_ACCUM))
          err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_channel_accum.sv
// tb/tb_channel_accum.sv - scoreboard bench driving SHIFT=0 and SHIFT=2 instances in lockstep
module tb_channel_accum;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [2:0] n_phase;
  logic signed [15:0] bias;
  logic in_valid;
  logic signed [15:0] d;
  logic busy0, valid0, err0, busy2, valid2, err2;
  logic signed [15:0] q0, q2;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int m_sum;

  typedef struct { int q0; int q2; int cyc; } exp_t;
  exp_t sb[$];

  channel_accum #(.DATA_LEN(16), .ACC_LEN(24), .SHIFT(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .n_phase(n_phase), .bias(bias),
    .in_valid(in_valid), .d(d), .busy(busy0), .valid(valid0), .q(q0), .err(err0)
  );

  channel_accum #(.DATA_LEN(16), .ACC_LEN(24), .SHIFT(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .n_phase(n_phase), .bias(bias),
    .in_valid(in_valid), .d(d), .busy(busy2), .valid(valid2), .q(q2), .err(err2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_q(input int sum, input int sh);
    int v;
    v = sum >>> sh;
    if (v < 0) return 0;
    if (v > 32767) return 32767;
    return v;
  endfunction

  always @(negedge clk) begin
    if (!rst && (valid0 || valid2)) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("valid_pair", int'(valid2), int'(valid0));
        check("q_shift0", int'(q0), e.q0);
        check("q_shift2", int'(q2), e.q2);
        check("valid_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic do_start(input int np, input int b);
    @(negedge clk);
    start = 1'b1;
    n_phase = 3'(np);
    bias = 16'(b);
    m_sum = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input int dv, input int hold, input bit last);
    exp_t e;
    d = 16'(dv);
    in_valid = 1'b1;
    m_sum += dv;
    if (last) begin
      e.q0 = model_q(m_sum, 0);
      e.q2 = model_q(m_sum, 2);
      e.cyc = cyc + 3;
      sb.push_back(e);
    end
    repeat (hold) @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; n_phase = '0; bias = '0; in_valid = 1'b0; d = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy0), 0);
    check("rst_valid", int'(valid0), 0);
    check("rst_q", int'(q0), 0);
    check("rst_err", int'(err0), 0);
    rst = 1'b0;

    do_start(2, 20);
    send(100, 1, 0); send(-50, 1, 0); send(30, 1, 1);
    repeat (3) @(negedge clk);
    check("t1_busy_after", int'(busy0), 0);
    check("t1_drained", sb.size(), 0);

    do_start(1, 0);
    send(7, 4, 0); send(8, 4, 1);
    repeat (3) @(negedge clk);
    check("t2_err", int'(err0), 0);

    do_start(0, 0);
    send(-500, 1, 1);
    repeat (3) @(negedge clk);
    do_start(2, 0);
    send(30000, 1, 0); send(30000, 1, 0); send(30000, 1, 1);
    repeat (3) @(negedge clk);

    do_start(0, 4);
    send(99, 1, 1);
    repeat (3) @(negedge clk);
    do_start(0, 0);
    send(-99, 1, 1);
    repeat (3) @(negedge clk);

    d = 16'sd77; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    check("t5_err_set", int'(err0), 1);
    check("t5_busy_idle", int'(busy0), 0);
    do_start(0, 0);
    check("t5_err_cleared", int'(err0), 0);
    @(negedge clk);
    start = 1'b1; n_phase = 3'd0; bias = '0; m_sum = 0;
    d = 16'sd1000; in_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("t5_busy_wait", int'(busy0), 1);
    send(5, 1, 1);
    repeat (3) @(negedge clk);
    check("t5_err_start_edge", int'(err0), 0);

    do_start(3, 0);
    send(1, 1, 0); send(2, 1, 0);
    do_start(0, 0);
    send(5, 1, 1);
    repeat (3) @(negedge clk);

    do_start(1, 0);
    send(9, 1, 0);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_busy", int'(busy0), 0);
    check("t6_rst_valid", int'(valid0), 0);
    check("t6_rst_q", int'(q0), 0);
    check("t6_rst_err", int'(err0), 0);
    check("t6_rst_q2", int'(q2), 0);
    rst = 1'b0;
    send(9, 1, 0);
    repeat (6) @(negedge clk);
    check("t6_no_valid_busy", int'(busy0), 0);
    check("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
